sphere_discriminant: RTL
========================

# sphere_discriminant

Front stage of the sphere-intersection path: accepts one ray/sphere pair per transaction, computes the quadratic coefficient B, the discriminant B² − 4AC and its integer square root, and delivers them over a valid/ready handshake to the DistanceCalculator input port. It produces RootDiscriminant, B, QuickIntersects and OldDistance, and drives that block's InputValid while observing its InputReady. The square root is iterative (one result bit per cycle), so the block is multi-cycle and holds one transaction at a time.

## Interface
- COORD_W, 12: signed width of each coordinate; radius is unsigned COORD_W. Only 12 is supported; internal widths are sized for it.
- CLK  in  1  single clock, all state on rising edge
- aresetn  in  1  asynchronous active-low reset
- RayOrigin  in  3*COORD_W  signed {X,Y,Z}, X in MSBs
- RayDir  in  3*COORD_W  signed {X,Y,Z}, not normalised
- SphereCenter  in  3*COORD_W  signed {X,Y,Z}
- SphereRadius  in  COORD_W  unsigned
- OldDistanceIn  in  32  current closest distance, passed through
- InValid  in  1  upstream request
- InReady  out  1  high only in IDLE
- RootDiscriminant  out  32  floor(sqrt(disc)) if disc ≥ 0, else 0
- B  out  32  signed, 2·(D·L)
- QuickIntersects  out  1  disc ≥ 0
- OldDistance  out  32  captured OldDistanceIn
- OutputValid  out  1  drives DistanceCalculator InputValid
- DownstreamReady  in  1  from DistanceCalculator InputReady

## Operation
- Math: L = O − C (13-bit per component); A = D·D; B = 2·(D·L); Cc = L·L − r²; disc = B² − 4·A·Cc in 64-bit signed. No overflow is possible for COORD_W=12. B sign-extended to 32 bits.
- States: IDLE → SUB → PROD → DISC → SQRT → OUT → IDLE.
- IDLE: InReady=1. On an edge with InValid=1, capture all inputs and go to SUB.
- SUB: register L.
- PROD: register A, B, Cc.
- DISC: register disc and QuickIntersects. Load the sqrt remainder with max(disc,0), clear the root, and set the 5-bit counter to 31.
- SQRT: restoring bit-serial square root, one result bit per edge starting at the MSB. The 32 iterations run counter 31..0, then the block goes to OUT.
- OUT: OutputValid=1. All data outputs are stable until an edge with DownstreamReady=1, which completes the transfer; return to IDLE.
- Data outputs change only on entry to OUT and hold their value in all other states.
- Only one transaction is in flight. InValid is ignored outside IDLE.

## Timing
- Reset (async assert, any state): state=IDLE, InReady=0, OutputValid=0, RootDiscriminant=0, B=0, QuickIntersects=0, OldDistance=0, counter=0.
- InReady is registered. It rises on the first rising edge after aresetn deasserts, is 0 from the accept edge until return to IDLE, and is 1 again the cycle after the output transfer edge.
- Latency from accept edge E0 to OutputValid: SUB after E0, PROD after E1, DISC after E2, SQRT after E3, OUT after E35. OutputValid is therefore visible 35 cycles after accept.
- Back-pressure: OutputValid stays high for any number of cycles with DownstreamReady=0. The transfer happens on the first edge where both are 1. DownstreamReady asserted before OUT is ignored.
- Minimum spacing between accepts is 37 cycles with DownstreamReady held high.
- Reset mid-operation aborts the transaction. No OutputValid is produced for it.

## Configuration
- SPHERE_EARLY_REJECT_EN defined: when disc < 0, DISC goes directly to OUT, so OutputValid appears 3 cycles after accept. Outputs are RootDiscriminant=0 and QuickIntersects=0.
- Not defined: negative disc runs all 32 SQRT iterations on 0. Latency is a constant 35 cycles and the outputs are identical.

## Test plan
- Reset, then release: InReady=0 during reset and 1 one edge after release. All outputs are 0.
- O=(0,0,−10), D=(0,0,1), C=(0,0,0), r=2, OldDistanceIn=1000 → B=−20 (0xFFFFFFEC), RootDiscriminant=4, QuickIntersects=1, OldDistance=1000. OutputValid rises 35 cycles after accept.
- O=(0,10,0), D=(0,−1,0), C=(10,−10,10), r=2 → disc=−784, B=−40 (0xFFFFFFD8), RootDiscriminant=0, QuickIntersects=0. Latency is 35 cycles without the macro and 3 cycles with SPHERE_EARLY_REJECT_EN.
- O=(0,0,0), D=(1,1,0), C=(10,10,0), r=3 → disc=72, B=−40, RootDiscriminant=8, QuickIntersects=1.
- Back-pressure: hold DownstreamReady=0 for 10 cycles in OUT. Outputs and OutputValid stay stable, InValid pulses are ignored, and the transfer occurs on the first edge with DownstreamReady=1.
- Assert aresetn low during SQRT (counter≈15): outputs go to 0 immediately. After release the next transaction (case 2 inputs) completes correctly.

Source files
------------

// File: rtl/sphere_discriminant.sv
// sphere_discriminant
// Front stage of the sphere-intersection path. For one ray/sphere pair it
// computes B = 2*(D.L), disc = B^2 - 4*A*Cc (L = O - C, A = D.D,
// Cc = L.L - r^2) and floor(sqrt(max(disc,0))). The results are handed to
// the DistanceCalculator over a valid/ready handshake. The square root is
// bit-serial (one root bit per cycle), so one transaction is held at a time.
//
// Optional feature macro: SPHERE_EARLY_REJECT_EN
//   defined   : a negative discriminant skips the square root (3-cycle latency)
//   undefined : latency is always 35 cycles; outputs are identical
//
// Ports:
//   CLK, aresetn      clock (rising edge) and async active-low reset
//   RayOrigin         {X,Y,Z} signed COORD_W each, X in MSBs
//   RayDir            {X,Y,Z} signed, not normalised
//   SphereCenter      {X,Y,Z} signed
//   SphereRadius      unsigned COORD_W
//   OldDistanceIn     passed through to OldDistance
//   InValid / InReady upstream handshake (InReady high only in IDLE)
//   RootDiscriminant  floor(sqrt(disc)) when disc >= 0, else 0
//   B                 signed 2*(D.L), sign-extended to 32 bits
//   QuickIntersects   disc >= 0
//   OldDistance       captured OldDistanceIn
//   OutputValid / DownstreamReady  downstream handshake
module sphere_discriminant #(
  parameter int COORD_W = 12
) (
  input  logic                   CLK,
  input  logic                   aresetn,
  input  logic [3*COORD_W-1:0]   RayOrigin,
  input  logic [3*COORD_W-1:0]   RayDir,
  input  logic [3*COORD_W-1:0]   SphereCenter,
  input  logic [COORD_W-1:0]     SphereRadius,
  input  logic [31:0]            OldDistanceIn,
  input  logic                   InValid,
  output logic                   InReady,
  output logic [31:0]            RootDiscriminant,
  output logic [31:0]            B,
  output logic                   QuickIntersects,
  output logic [31:0]            OldDistance,
  output logic                   OutputValid,
  input  logic                   DownstreamReady
);

  localparam int CW = COORD_W;
  localparam int LW = COORD_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUB  = 3'd1,
    ST_PROD = 3'd2,
    ST_DISC = 3'd3,
    ST_SQRT = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  // Three-term signed dot product; 32 bits cannot overflow for 12-bit inputs.
  function automatic logic signed [31:0] dot3(
    input logic signed [31:0] ax, input logic signed [31:0] ay, input logic signed [31:0] az,
    input logic signed [31:0] bx, input logic signed [31:0] by, input logic signed [31:0] bz);
    return (ax * bx) + (ay * by) + (az * bz);
  endfunction

  state_t state_r, state_next_s;

  logic              in_ready_r, out_valid_r;
  logic [3*CW-1:0]   org_r, dir_r, ctr_r;
  logic [CW-1:0]     radius_r;
  logic [31:0]       old_r;
  logic signed [LW-1:0] l_x_r, l_y_r, l_z_r;
  logic signed [31:0]   a_r, b_r, c_r;
  logic              qi_r;
  logic [63:0]       sq_rad_r;
  logic [35:0]       sq_rem_r;
  logic [31:0]       sq_root_r;
  logic [4:0]        cnt_r;
  logic [31:0]       root_out_r, b_out_r, old_out_r;
  logic              qi_out_r;

  logic signed [CW-1:0] org_x_s, org_y_s, org_z_s;
  logic signed [CW-1:0] dir_x_s, dir_y_s, dir_z_s;
  logic signed [CW-1:0] ctr_x_s, ctr_y_s, ctr_z_s;
  logic signed [31:0]   a_s, b_s, c_s, r2_s;
  logic signed [63:0]   disc_s;
  logic [35:0]          rem_shift_s, trial_s, rem_next_s;
  logic [31:0]          root_next_s;

  assign org_x_s = $signed(org_r[3*CW-1 -: CW]);
  assign org_y_s = $signed(org_r[2*CW-1 -: CW]);
  assign org_z_s = $signed(org_r[CW-1 -: CW]);
  assign dir_x_s = $signed(dir_r[3*CW-1 -: CW]);
  assign dir_y_s = $signed(dir_r[2*CW-1 -: CW]);
  assign dir_z_s = $signed(dir_r[CW-1 -: CW]);
  assign ctr_x_s = $signed(ctr_r[3*CW-1 -: CW]);
  assign ctr_y_s = $signed(ctr_r[2*CW-1 -: CW]);
  assign ctr_z_s = $signed(ctr_r[CW-1 -: CW]);

  // Quadratic coefficients and discriminant from the registered stage values.
  always_comb begin
    a_s    = dot3(32'(dir_x_s), 32'(dir_y_s), 32'(dir_z_s),
                  32'(dir_x_s), 32'(dir_y_s), 32'(dir_z_s));
    b_s    = dot3(32'(dir_x_s), 32'(dir_y_s), 32'(dir_z_s),
                  32'(l_x_r), 32'(l_y_r), 32'(l_z_r)) * 32'sd2;
    r2_s   = $signed(32'(radius_r) * 32'(radius_r));
    c_s    = dot3(32'(l_x_r), 32'(l_y_r), 32'(l_z_r),
                  32'(l_x_r), 32'(l_y_r), 32'(l_z_r)) - r2_s;
    disc_s = (64'(b_r) * 64'(b_r)) - (64'sd4 * 64'(a_r) * 64'(c_r));
  end

  // One restoring square-root step: bring down two radicand bits and try
  // subtracting (4*root + 1).
  always_comb begin
    rem_shift_s = (sq_rem_r << 2) | {34'd0, sq_rad_r[63:62]};
    trial_s     = {2'b00, sq_root_r, 2'b01};
    if (rem_shift_s >= trial_s) begin
      rem_next_s  = rem_shift_s - trial_s;
      root_next_s = {sq_root_r[30:0], 1'b1};
    end else begin
      rem_next_s  = rem_shift_s;
      root_next_s = {sq_root_r[30:0], 1'b0};
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: if (InValid && in_ready_r) state_next_s = ST_SUB; else state_next_s = ST_IDLE;
      ST_SUB:  state_next_s = ST_PROD;
      ST_PROD: state_next_s = ST_DISC;
      ST_DISC: begin
`ifdef SPHERE_EARLY_REJECT_EN
        if (disc_s < 64'sd0) state_next_s = ST_OUT; else state_next_s = ST_SQRT;
`else
        state_next_s = ST_SQRT;
`endif
      end
      ST_SQRT: if (cnt_r == 5'd0) state_next_s = ST_OUT; else state_next_s = ST_SQRT;
      ST_OUT:  if (DownstreamReady) state_next_s = ST_IDLE; else state_next_s = ST_OUT;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) state_r <= ST_IDLE;
    else          state_r <= state_next_s;
  end

  // Datapath, handshake flags and output registers.
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      org_r       <= '0;
      dir_r       <= '0;
      ctr_r       <= '0;
      radius_r    <= '0;
      old_r       <= 32'd0;
      l_x_r       <= '0;
      l_y_r       <= '0;
      l_z_r       <= '0;
      a_r         <= 32'sd0;
      b_r         <= 32'sd0;
      c_r         <= 32'sd0;
      qi_r        <= 1'b0;
      sq_rad_r    <= 64'd0;
      sq_rem_r    <= 36'd0;
      sq_root_r   <= 32'd0;
      cnt_r       <= 5'd0;
      root_out_r  <= 32'd0;
      b_out_r     <= 32'd0;
      old_out_r   <= 32'd0;
      qi_out_r    <= 1'b0;
    end else begin
      // Flags are registered copies of the state being entered.
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_OUT);
      case (state_r)
        ST_IDLE: begin
          if (InValid && in_ready_r) begin
            org_r    <= RayOrigin;
            dir_r    <= RayDir;
            ctr_r    <= SphereCenter;
            radius_r <= SphereRadius;
            old_r    <= OldDistanceIn;
          end
        end
        ST_SUB: begin
          l_x_r <= LW'(org_x_s) - LW'(ctr_x_s);
          l_y_r <= LW'(org_y_s) - LW'(ctr_y_s);
          l_z_r <= LW'(org_z_s) - LW'(ctr_z_s);
        end
        ST_PROD: begin
          a_r <= a_s;
          b_r <= b_s;
          c_r <= c_s;
        end
        ST_DISC: begin
          // A negative discriminant yields a zero root by rooting 0.
          qi_r      <= (disc_s >= 64'sd0);
          sq_rad_r  <= disc_s[63] ? 64'd0 : disc_s;
          sq_rem_r  <= 36'd0;
          sq_root_r <= 32'd0;
          cnt_r     <= 5'd31;
        end
        ST_SQRT: begin
          sq_rad_r  <= {sq_rad_r[61:0], 2'b00};
          sq_rem_r  <= rem_next_s;
          sq_root_r <= root_next_s;
          if (cnt_r != 5'd0) cnt_r <= cnt_r - 5'd1;
        end
        default: ;
      endcase
      // Outputs load only on entry to OUT; the last root bit comes from the
      // step completing on that same edge.
      if ((state_next_s == ST_OUT) && (state_r != ST_OUT)) begin
        root_out_r <= (state_r == ST_SQRT) ? root_next_s : 32'd0;
        qi_out_r   <= (state_r == ST_SQRT) ? qi_r : 1'b0;
        b_out_r    <= b_r;
        old_out_r  <= old_r;
      end
    end
  end

  assign InReady          = in_ready_r;
  assign OutputValid      = out_valid_r;
  assign RootDiscriminant = root_out_r;
  assign B                = b_out_r;
  assign QuickIntersects  = qi_out_r;
  assign OldDistance      = old_out_r;

endmodule
